// File: rtl/mux_shift_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_shift_unit_pkg
//  Description : Shared defaults and constants for the mono I2S-style serial
//                output framer (mux_shift_unit and its capture sub-block).
//  Contents    : DEF_DATA_W / DEF_SLOT_W default widths, DELAY_BITS (number of
//                I2S delay bits ahead of the MSB), DELAY_BIT_VAL (its level),
//                cnt_w() helper for saturating counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_shift_unit_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_SLOT_W = 32;

  // One delay bit precedes the MSB in every slot, and it is always low.
  localparam int   DELAY_BITS    = 1;
  localparam logic DELAY_BIT_VAL = 1'b0;

  // Width of a counter that must be able to hold the value n without wrapping.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_shift_capture.sv
`default_nettype none
// ============================================================================
//  Module      : mux_shift_capture
//  Description : Bit-serial word capture. Shifts sum_res_i (MSB first) into a
//                DATA_W-bit register every clk; the registered rising edge of
//                last_shift_i moves the word (including the current bit as LSB)
//                into the hold register and clears the capture register.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                last_shift_i    - word-end marker (rising edge closes a word)
//                sum_res_i       - serial data bit, sampled every clk
//                hold_o          - most recently completed word
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_shift_capture
  import mux_shift_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              last_shift_i,
  input  logic              sum_res_i,
  output logic [DATA_W-1:0] hold_o
);

  logic [DATA_W-1:0] capture_q, capture_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              ls_q;
  logic [DATA_W-1:0] shifted;
  logic              ls_rise;

  always_comb begin
    shifted   = {capture_q[DATA_W-2:0], sum_res_i};
    ls_rise   = last_shift_i & ~ls_q;
    // The bit arriving with the rise is the word LSB, so the transfer takes
    // the already-shifted value; the capture restarts empty for the next word.
    capture_d = ls_rise ? '0 : shifted;
    hold_d    = ls_rise ? shifted : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      capture_q <= '0;
      hold_q    <= '0;
      ls_q      <= 1'b0;
    end else begin
      capture_q <= capture_d;
      hold_q    <= hold_d;
      ls_q      <= last_shift_i;
    end
  end

  assign hold_o = hold_q;

endmodule
`default_nettype wire

// File: rtl/mux_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mux_shift_unit
//  Description : Serial output framer. Captures the bit-serial summed result
//                into words and, on every lr_clk edge, sends the latest word
//                I2S-style: one delay bit, DATA_W bits MSB first, then zeros.
//                The same word fills left and right slots (mono).
//  Ports       : clk        - system clock, one output bit per cycle
//                rst        - synchronous active-high reset
//                lr_clk     - word select; either edge starts a slot
//                last_shift - word-end marker, rising edge closes a word
//                sum_res    - serial result bit, MSB first
//                out        - registered serial data output
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_shift_unit
  import mux_shift_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic lr_clk,
  input  logic last_shift,
  input  logic sum_res,
  output logic out
);

  localparam int            KW     = cnt_w(DATA_W);
  localparam logic [KW-1:0] K_LAST = KW'(DATA_W);

  // A slot must at least fit the delay bit plus the whole payload.
  if (SLOT_W < DATA_W + DELAY_BITS) begin : g_slot_too_short
    $error("mux_shift_unit: SLOT_W must be >= DATA_W + DELAY_BITS");
  end

  logic [DATA_W-1:0] hold;

  mux_shift_capture #(
    .DATA_W (DATA_W)
  ) u_capture (
    .clk          (clk),
    .rst          (rst),
    .last_shift_i (last_shift),
    .sum_res_i    (sum_res),
    .hold_o       (hold)
  );

  logic              lr_q;
  logic              lr_edge;
  logic [KW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] slot_q, slot_d;
  logic              out_q, out_d;

  assign lr_edge = lr_clk ^ lr_q;

  always_comb begin
    k_d    = k_q;
    slot_d = slot_q;
    out_d  = 1'b0;
    if (lr_edge) begin
      // Latch the registered hold value: a word closing on this same cycle
      // is not visible yet and goes out from the next slot.
      out_d  = DELAY_BIT_VAL;
      slot_d = hold;
      k_d    = '0;
    end else if (k_q < K_LAST) begin
      out_d  = slot_q[DATA_W-1];
      slot_d = {slot_q[DATA_W-2:0], 1'b0};
      k_d    = k_q + KW'(1);
    end
    // Otherwise the counter stays saturated and the slot is padded with zeros.
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lr_q   <= 1'b0;
      k_q    <= '0;
      slot_q <= '0;
      out_q  <= 1'b0;
    end else begin
      lr_q   <= lr_clk;
      k_q    <= k_d;
      slot_q <= slot_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_shift_unit
//  Description : Directed self-checking bench for mux_shift_unit. Inputs are
//                driven and the output sampled on the falling clk edge; lr_clk
//                is toggled by the bench to start each slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_shift_unit;

  localparam int DATA_W = 24;
  localparam int SLOT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic lr_clk;
  logic last_shift;
  logic sum_res;
  logic out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_shift_unit #(
    .DATA_W (DATA_W),
    .SLOT_W (SLOT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lr_clk     (lr_clk),
    .last_shift (last_shift),
    .sum_res    (sum_res),
    .out        (out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Shift nbits of value (MSB first) with last_shift low.
  task automatic shift_bits(input logic [31:0] value, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sum_res = value[i];
      @(negedge clk);
    end
    sum_res = 1'b0;
  endtask

  // Shift a word of nbits; last_shift rises with the LSB and stays high for
  // hold_cycles cycles (extra cycles shift ones).
  task automatic load_word(input logic [31:0] value, input int nbits, input int hold_cycles);
    shift_bits(value >> 1, nbits - 1);
    sum_res    = value[0];
    last_shift = 1'b1;
    @(negedge clk);
    for (int i = 1; i < hold_cycles; i++) begin
      sum_res = 1'b1;
      @(negedge clk);
    end
    last_shift = 1'b0;
    sum_res    = 1'b0;
  endtask

  // Start a slot by toggling lr_clk and collect len output bits, MSB first.
  // Optionally raise last_shift (with bit ls_bit) on the same cycle.
  task automatic run_slot(input int len, input logic [DATA_W-1:0] word, input string tag,
                          input bit ls_pulse, input logic ls_bit);
    logic [SLOT_W-1:0] got, exp, mask;
    got    = '0;
    lr_clk = ~lr_clk;
    if (ls_pulse) begin
      last_shift = 1'b1;
      sum_res    = ls_bit;
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) begin
        last_shift = 1'b0;
        sum_res    = 1'b0;
      end
      got[SLOT_W-1-i] = out;
    end
    exp  = {1'b0, word, {(SLOT_W-DATA_W-1){1'b0}}};
    mask = {SLOT_W{1'b1}} << (SLOT_W - len);
    check(tag, got, exp & mask);
  endtask

  logic [DATA_W-1:0] wa;
  logic [DATA_W-1:0] wb;

  initial begin
    wa         = 24'hA5C396;
    wb         = 24'h3C5A0F;
    rst        = 1'b1;
    lr_clk     = 1'b0;
    last_shift = 1'b0;
    sum_res    = 1'b0;

    // Reset with toggling inputs: out held low.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      lr_clk     = 1'($urandom_range(0, 1));
      last_shift = 1'($urandom_range(0, 1));
      sum_res    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_out", {31'b0, out}, 32'h0);
    end
    rst        = 1'b0;
    lr_clk     = 1'b0;
    last_shift = 1'b0;
    sum_res    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_reset", {31'b0, out}, 32'h0);
    end
    run_slot(SLOT_W, 24'h0, "first_slot_zero", 1'b0, 1'b0);

    // Basic word: 16 ones then the rise with a zero bit -> 0x01FFFE.
    load_word(32'h0001FFFE, 17, 1);
    run_slot(SLOT_W, 24'h01FFFE, "basic_word", 1'b0, 1'b0);

    // last_shift held high for 16 cycles: only one transfer.
    load_word(32'h0001FFFE, 17, 16);
    run_slot(SLOT_W, 24'h01FFFE, "held_ls_slot_a", 1'b0, 1'b0);
    run_slot(SLOT_W, 24'h01FFFE, "held_ls_slot_b", 1'b0, 1'b0);

    // 28 bits before the rise: only the last 24 survive.
    load_word(32'h0FA5C396, 28, 1);
    run_slot(SLOT_W, wa, "overflow_word", 1'b0, 1'b0);

    // Coincident rise and lr edge: old word now, new word next slot.
    shift_bits(32'(wb) >> 1, DATA_W - 1);
    run_slot(SLOT_W, wa, "coinc_old_word", 1'b1, wb[0]);
    run_slot(SLOT_W, wb, "coinc_new_word", 1'b0, 1'b0);

    // Short slots of 10 cycles: delay bit plus top 9 bits, then restart.
    run_slot(10, wb, "short_slot_1", 1'b0, 1'b0);
    run_slot(10, wb, "short_slot_2", 1'b0, 1'b0);
    run_slot(10, wb, "short_slot_3", 1'b0, 1'b0);

    // Reset during payload bit 5.
    lr_clk = ~lr_clk;
    @(negedge clk);
    check("mid_delay_bit", {31'b0, out}, 32'h0);
    for (int p = 1; p <= 5; p++) @(negedge clk);
    check("mid_payload_bit5", {31'b0, out}, {31'b0, wb[DATA_W-5]});
    rst    = 1'b1;
    lr_clk = 1'b0;
    @(negedge clk);
    check("mid_reset_out", {31'b0, out}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_mid_reset_idle", {31'b0, out}, 32'h0);
    end
    run_slot(SLOT_W, 24'h0, "post_reset_slot_zero", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
